// File: rtl/mini16_hub_pkg.sv
// Shared constants for the mini16 manycore hub: master address regions,
// I/O register indices and the master read-source select.
package mini16_hub_pkg;

  localparam logic [3:0] REG_IO     = 4'h2;
  localparam logic [3:0] REG_S2M    = 4'h3;
  localparam logic [3:0] REG_M2S    = 4'h4;
  localparam logic [3:0] BCAST_CORE = 4'hF;

  localparam logic [3:0] IO_LED      = 4'd0;
  localparam logic [3:0] IO_PE_RESET = 4'd1;
  localparam logic [3:0] IO_CORES    = 4'd8;
  localparam logic [3:0] IO_WIDTH    = 4'd9;
  localparam logic [3:0] IO_FEAT     = 4'd10;

  typedef enum logic [1:0] {SEL_NONE, SEL_IO, SEL_S2M} rd_sel_e;

endpackage

// File: rtl/mini16_dp_ram.sv
// Simple dual-port RAM: WR_PORTS write lanes plus one registered, read-first
// read port. Lanes must target disjoint addresses when written together.
module mini16_dp_ram #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 8,
  parameter int WR_PORTS = 1
) (
  input  logic                         clk,
  input  logic [WR_PORTS-1:0]          we,
  input  logic [WR_PORTS*ADDR_W-1:0]   waddr,
  input  logic [WR_PORTS*WIDTH-1:0]    wdata,
  input  logic [ADDR_W-1:0]            raddr,
  output logic [WIDTH-1:0]             rdata
);

  // NOTE: memories have no reset; this initialiser only gives simulation a known all-zero start.
  logic [WIDTH-1:0] mem [1<<ADDR_W] = '{default: '0};

  // NOTE: non-blocking assignments make the read see the pre-write word (read-first).
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    for (int p = 0; p < WR_PORTS; p++) begin
      if (we[p]) mem[waddr[p*ADDR_W +: ADDR_W]] <= wdata[p*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mini16_manycore_hub.sv
// mini16 manycore hub: master-bus decode, per-PE m2s RAMs, shared s2m RAM,
// I/O registers, LEDs and PE resets. Optional feature macro: BROADCAST_EN.
module mini16_manycore_hub
  import mini16_hub_pkg::*;
#(
  parameter int CORES        = 4,
  parameter int WIDTH_P_D    = 32,
  parameter int DEPTH_M2S    = 8,
  parameter int DEPTH_S2M_PE = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [15:0]                     mst_addr,
  input  logic                            mst_we,
  input  logic [15:0]                     mst_wdata,
  output logic [15:0]                     mst_rdata,
  output logic [CORES-1:0]                pe_reset,
  input  logic [CORES*DEPTH_M2S-1:0]      pe_m2s_addr,
  output logic [CORES*WIDTH_P_D-1:0]      pe_m2s_rdata,
  input  logic [CORES-1:0]                pe_s2m_we,
  input  logic [CORES*DEPTH_S2M_PE-1:0]   pe_s2m_addr,
  input  logic [CORES*WIDTH_P_D-1:0]      pe_s2m_wdata,
  output logic [15:0]                     led
);

  localparam int S2M_AW = $clog2(CORES << DEPTH_S2M_PE);
`ifdef BROADCAST_EN
  localparam logic BCAST = 1'b1;
`else
  localparam logic BCAST = 1'b0;
`endif

  logic [3:0]  region, core, io_idx, s2m_core;
  logic [15:0] io_reg_w [16];
  logic [15:0] io_rd_val, io_rdata_q;
  rd_sel_e     rd_sel_d, rd_sel_q;

  assign region   = mst_addr[15:12];
  assign core     = mst_addr[11:8];
  assign io_idx   = mst_addr[3:0];
  assign s2m_core = mst_addr[DEPTH_S2M_PE+3:DEPTH_S2M_PE];

  assign led      = io_reg_w[IO_LED];
  assign pe_reset = io_reg_w[IO_PE_RESET][CORES-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    io_rd_val = '0;
    if (!io_idx[3]) begin
      io_rd_val = io_reg_w[io_idx];
    end else begin
      case (io_idx)
        IO_CORES: io_rd_val = 16'(CORES);
        IO_WIDTH: io_rd_val = 16'(WIDTH_P_D);
        IO_FEAT:  io_rd_val = {15'b0, BCAST};
        default:  io_rd_val = '0;
      endcase
    end
  end

  always_comb begin
    rd_sel_d = SEL_NONE;
    if (region == REG_IO)                                 rd_sel_d = SEL_IO;
    else if (region == REG_S2M && int'(s2m_core) < CORES) rd_sel_d = SEL_S2M;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) io_reg_w[i] <= '0;
      io_reg_w[IO_PE_RESET] <= '1;
      rd_sel_q   <= SEL_NONE;
      io_rdata_q <= '0;
    end else begin
      if (mst_we && region == REG_IO) io_reg_w[io_idx] <= mst_wdata;
      rd_sel_q   <= rd_sel_d;
      io_rdata_q <= io_rd_val;
    end
  end

  // Per-PE m2s RAMs; core 0xF is a broadcast slot only when the feature is built in.
  for (genvar c = 0; c < CORES; c++) begin : g_m2s
    logic we;
    assign we = mst_we && !reset && region == REG_M2S &&
                ((core == 4'(c) && core != BCAST_CORE) || (BCAST && core == BCAST_CORE));

    mini16_dp_ram #(.WIDTH(WIDTH_P_D), .ADDR_W(DEPTH_M2S), .WR_PORTS(1)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (mst_addr[DEPTH_M2S-1:0]),
      .wdata (WIDTH_P_D'(mst_wdata)),
      .raddr (pe_m2s_addr[c*DEPTH_M2S +: DEPTH_M2S]),
      .rdata (pe_m2s_rdata[c*WIDTH_P_D +: WIDTH_P_D])
    );
  end

  // Shared s2m RAM: each PE owns a fixed slice, so all lanes may write together.
  logic [CORES*S2M_AW-1:0] s2m_waddr;
  logic [WIDTH_P_D-1:0]    s2m_q;
  logic                    unused_s2m;

  for (genvar c = 0; c < CORES; c++) begin : g_s2m_addr
    assign s2m_waddr[c*S2M_AW +: S2M_AW] =
      S2M_AW'((c << DEPTH_S2M_PE) + int'(pe_s2m_addr[c*DEPTH_S2M_PE +: DEPTH_S2M_PE]));
  end

  mini16_dp_ram #(.WIDTH(WIDTH_P_D), .ADDR_W(S2M_AW), .WR_PORTS(CORES)) u_s2m (
    .clk   (clk),
    .we    (pe_s2m_we & {CORES{~reset}}),
    .waddr (s2m_waddr),
    .wdata (pe_s2m_wdata),
    .raddr (S2M_AW'({s2m_core, mst_addr[DEPTH_S2M_PE-1:0]})),
    .rdata (s2m_q)
  );

  assign unused_s2m = ^s2m_q;

  always_comb begin
    mst_rdata = '0;
    case (rd_sel_q)
      SEL_IO:  mst_rdata = io_rdata_q;
      SEL_S2M: mst_rdata = s2m_q[15:0];
      default: mst_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mini16_manycore_hub.sv
// Self-checking bench for mini16_manycore_hub with a behavioural memory-map model.
// Define BROADCAST_EN consistently for bench and RTL to exercise the broadcast build.
module tb_mini16_manycore_hub;

  localparam int CORES = 4;
  localparam int W     = 32;
  localparam int DM    = 8;
  localparam int DS    = 4;
`ifdef BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [15:0]           mst_addr, mst_wdata, mst_rdata, led;
  logic                  mst_we;
  logic [CORES-1:0]      pe_reset, pe_s2m_we;
  logic [CORES*DM-1:0]   pe_m2s_addr;
  logic [CORES*W-1:0]    pe_m2s_rdata, pe_s2m_wdata;
  logic [CORES*DS-1:0]   pe_s2m_addr;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the memory map
  logic [31:0] m_m2s [CORES][256];
  logic [15:0] m_s2m [CORES][16];
  logic [15:0] m_io  [16];

  always #5 clk = ~clk;

  mini16_manycore_hub #(.CORES(CORES), .WIDTH_P_D(W), .DEPTH_M2S(DM), .DEPTH_S2M_PE(DS)) dut (
    .clk          (clk),
    .reset        (reset),
    .mst_addr     (mst_addr),
    .mst_we       (mst_we),
    .mst_wdata    (mst_wdata),
    .mst_rdata    (mst_rdata),
    .pe_reset     (pe_reset),
    .pe_m2s_addr  (pe_m2s_addr),
    .pe_m2s_rdata (pe_m2s_rdata),
    .pe_s2m_we    (pe_s2m_we),
    .pe_s2m_addr  (pe_s2m_addr),
    .pe_s2m_wdata (pe_s2m_wdata),
    .led          (led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    int idx  = int'(a[3:0]);
    int core = int'(a[7:4]);
    if (a[15:12] == 4'h2) begin
      if (idx < 8)   return m_io[idx];
      if (idx == 8)  return 16'(CORES);
      if (idx == 9)  return 16'(W);
      if (idx == 10) return BCAST ? 16'd1 : 16'd0;
      return 16'd0;
    end
    if (a[15:12] == 4'h3) return (core < CORES) ? m_s2m[core][idx] : 16'd0;
    return 16'd0;
  endfunction

  function automatic void model_master_write(input logic [15:0] a, input logic [15:0] d);
    int core = int'(a[11:8]);
    if (a[15:12] == 4'h2) m_io[a[3:0]] = d;
    if (a[15:12] == 4'h4) begin
      if (core == 15 && BCAST)
        for (int c = 0; c < CORES; c++) m_m2s[c][a[7:0]] = {16'h0, d};
      else if (core < CORES)
        m_m2s[core][a[7:0]] = {16'h0, d};
    end
  endfunction

  task automatic mst_write(input logic [15:0] a, input logic [15:0] d);
    mst_addr = a; mst_wdata = d; mst_we = 1'b1;
    tick();
    mst_we = 1'b0;
    model_master_write(a, d);
  endtask

  task automatic mst_read(input logic [15:0] a, output logic [15:0] d);
    mst_addr = a; mst_we = 1'b0;
    tick();
    d = mst_rdata;
  endtask

  task automatic set_pe_addrs(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3);
    pe_m2s_addr = {w3, w2, w1, w0};
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b1; mst_addr = 16'h0; mst_we = 1'b0; mst_wdata = 16'h0;
    pe_m2s_addr = '0; pe_s2m_we = '0; pe_s2m_addr = '0; pe_s2m_wdata = '0;
    repeat (10) tick();
    tests_run++;
    if (led !== 16'h0) begin tests_failed++; $display("FAIL reset_led got %h want 0000", led); end
    tests_run++;
    if (pe_reset !== 4'b1111) begin tests_failed++; $display("FAIL reset_pe_reset got %b want 1111", pe_reset); end
    tests_run++;
    if (mst_rdata !== 16'h0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0000", mst_rdata); end
    reset = 1'b0;
    mst_read(16'h2008, d);
    tests_run++;
    if (d !== 16'd4) begin tests_failed++; $display("FAIL io_cores got %h want 0004", d); end
    mst_read(16'h2009, d);
    tests_run++;
    if (d !== 16'd32) begin tests_failed++; $display("FAIL io_width got %h want 0020", d); end
    mst_read(16'h200A, d);
    tests_run++;
    if (d !== exp_read(16'h200A)) begin tests_failed++; $display("FAIL io_feat got %h want %h", d, exp_read(16'h200A)); end
    mst_read(16'h2001, d);
    tests_run++;
    if (d !== 16'hFFFF) begin tests_failed++; $display("FAIL io_pe_reset_rb got %h want ffff", d); end
  endtask

  task automatic test_io();
    logic [15:0] d, a;
    mst_write(16'h2000, 16'h00A5);
    tests_run++;
    if (led !== 16'h00A5) begin tests_failed++; $display("FAIL led got %h want 00a5", led); end
    mst_write(16'h2001, 16'h0005);
    tests_run++;
    if (pe_reset !== 4'b0101) begin tests_failed++; $display("FAIL pe_reset got %b want 0101", pe_reset); end
    for (int i = 0; i < 16; i++) begin
      a = 16'h2000 | 16'($urandom_range(2, 15));
      mst_write(a, 16'($urandom));
      a = 16'h2000 | 16'($urandom_range(0, 15));
      mst_read(a, d);
      tests_run++;
      if (d !== exp_read(a)) begin tests_failed++; $display("FAIL io_rw addr %h got %h want %h", a, d, exp_read(a)); end
    end
  endtask

  task automatic test_m2s();
    logic [15:0] a;
    logic [7:0]  w [CORES];
    mst_write(16'h4203, 16'h1234);
    set_pe_addrs(8'd3, 8'd3, 8'd3, 8'd3);
    tick();
    for (int c = 0; c < CORES; c++) begin
      tests_run++;
      if (pe_m2s_rdata[c*W +: W] !== ((c == 2) ? 32'h0000_1234 : 32'h0)) begin
        tests_failed++;
        $display("FAIL m2s_first pe%0d got %h want %h", c, pe_m2s_rdata[c*W +: W], (c == 2) ? 32'h1234 : 32'h0);
      end
    end
    for (int i = 0; i < 24; i++) begin
      a = {4'h4, 4'($urandom_range(0, 15)), 4'h0, 4'($urandom)};
      mst_write(a, 16'($urandom));
    end
    mst_write(16'h4907, 16'hBEEF);
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < CORES; c++) w[c] = (i == 0) ? 8'd7 : 8'($urandom_range(0, 15));
      set_pe_addrs(w[0], w[1], w[2], w[3]);
      tick();
      for (int c = 0; c < CORES; c++) begin
        tests_run++;
        if (pe_m2s_rdata[c*W +: W] !== m_m2s[c][w[c]]) begin
          tests_failed++;
          $display("FAIL m2s_rand pe%0d word %0d got %h want %h", c, w[c], pe_m2s_rdata[c*W +: W], m_m2s[c][w[c]]);
        end
      end
    end
  endtask

  task automatic test_m2s_read_first();
    logic [31:0] old_v;
    old_v = m_m2s[1][5];
    set_pe_addrs(8'd0, 8'd5, 8'd0, 8'd0);
    mst_write(16'h4105, ~old_v[15:0]);
    tests_run++;
    if (pe_m2s_rdata[W +: W] !== old_v) begin
      tests_failed++; $display("FAIL m2s_read_first got %h want %h", pe_m2s_rdata[W +: W], old_v);
    end
    tick();
    tests_run++;
    if (pe_m2s_rdata[W +: W] !== m_m2s[1][5]) begin
      tests_failed++; $display("FAIL m2s_after_write got %h want %h", pe_m2s_rdata[W +: W], m_m2s[1][5]);
    end
  endtask

  task automatic test_s2m();
    logic [15:0] d, a;
    pe_s2m_we = 4'b0010; pe_s2m_addr = {4'd0, 4'd0, 4'd2, 4'd0};
    pe_s2m_wdata = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    tick();
    pe_s2m_we = '0;
    m_s2m[1][2] = 16'hBEEF;
    mst_read(16'h3012, d);
    tests_run++;
    if (d !== 16'hBEEF) begin tests_failed++; $display("FAIL s2m_first got %h want beef", d); end
    for (int i = 0; i < 10; i++) begin
      pe_s2m_we = 4'($urandom);
      for (int c = 0; c < CORES; c++) begin
        pe_s2m_addr[c*DS +: DS]  = 4'($urandom);
        pe_s2m_wdata[c*W +: W]   = $urandom;
      end
      tick();
      for (int c = 0; c < CORES; c++)
        if (pe_s2m_we[c]) m_s2m[c][pe_s2m_addr[c*DS +: DS]] = pe_s2m_wdata[c*W +: 16];
      pe_s2m_we = '0;
      a = {4'h3, 4'h0, 4'($urandom_range(0, 4)), 4'($urandom)};
      mst_read(a, d);
      tests_run++;
      if (d !== exp_read(a)) begin tests_failed++; $display("FAIL s2m_rand addr %h got %h want %h", a, d, exp_read(a)); end
    end
    mst_read(16'h5000, d);
    tests_run++;
    if (d !== 16'h0) begin tests_failed++; $display("FAIL other_region got %h want 0000", d); end
  endtask

  task automatic test_s2m_read_first();
    logic [15:0] old_v, d;
    old_v = m_s2m[0][5];
    mst_addr = 16'h3005; mst_we = 1'b0;
    pe_s2m_we = 4'b0001; pe_s2m_addr = '0; pe_s2m_addr[3:0] = 4'd5;
    pe_s2m_wdata = '0; pe_s2m_wdata[31:0] = {16'h1111, ~old_v};
    tick();
    pe_s2m_we = '0;
    m_s2m[0][5] = ~old_v;
    tests_run++;
    if (mst_rdata !== old_v) begin tests_failed++; $display("FAIL s2m_read_first got %h want %h", mst_rdata, old_v); end
    mst_read(16'h3005, d);
    tests_run++;
    if (d !== ~old_v) begin tests_failed++; $display("FAIL s2m_after_write got %h want %h", d, ~old_v); end
  endtask

  task automatic test_broadcast();
    mst_write(16'h4F07, 16'h0042);
    set_pe_addrs(8'd7, 8'd7, 8'd7, 8'd7);
    tick();
    for (int c = 0; c < CORES; c++) begin
      tests_run++;
      if (pe_m2s_rdata[c*W +: W] !== m_m2s[c][7]) begin
        tests_failed++; $display("FAIL bcast pe%0d got %h want %h", c, pe_m2s_rdata[c*W +: W], m_m2s[c][7]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    reset = 1'b1;
    mst_addr = 16'h2000; mst_wdata = 16'h5A5A; mst_we = 1'b1;
    pe_s2m_we = 4'b0100; pe_s2m_addr = {4'd0, 4'd1, 4'd0, 4'd0};
    pe_s2m_wdata = {32'h0, ~{16'h0, m_s2m[2][1]}, 32'h0, 32'h0};
    tick();
    tests_run++;
    if (mst_rdata !== 16'h0) begin tests_failed++; $display("FAIL mid_reset_rdata got %h want 0000", mst_rdata); end
    mst_addr = 16'h4203; mst_wdata = 16'h7777;
    tick();
    reset = 1'b0; mst_we = 1'b0; pe_s2m_we = '0;
    for (int i = 0; i < 16; i++) m_io[i] = 16'h0;
    m_io[1] = 16'hFFFF;
    tests_run++;
    if (led !== 16'h0) begin tests_failed++; $display("FAIL mid_reset_led got %h want 0000", led); end
    tests_run++;
    if (pe_reset !== 4'b1111) begin tests_failed++; $display("FAIL mid_reset_pe_reset got %b want 1111", pe_reset); end
    mst_read(16'h3021, d);
    tests_run++;
    if (d !== m_s2m[2][1]) begin tests_failed++; $display("FAIL mid_reset_s2m got %h want %h", d, m_s2m[2][1]); end
    set_pe_addrs(8'd3, 8'd3, 8'd3, 8'd3);
    tick();
    tests_run++;
    if (pe_m2s_rdata[2*W +: W] !== m_m2s[2][3]) begin
      tests_failed++; $display("FAIL mid_reset_m2s got %h want %h", pe_m2s_rdata[2*W +: W], m_m2s[2][3]);
    end
  endtask

  initial begin
    for (int c = 0; c < CORES; c++) begin
      for (int i = 0; i < 256; i++) m_m2s[c][i] = 32'h0;
      for (int i = 0; i < 16; i++) m_s2m[c][i] = 16'h0;
    end
    for (int i = 0; i < 16; i++) m_io[i] = 16'h0;
    m_io[1] = 16'hFFFF;
    test_reset();
    test_io();
    test_m2s();
    test_m2s_read_first();
    test_s2m();
    test_s2m_read_first();
    test_broadcast();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
